demux_1x4: RTL and testbench
============================

DEMUX_1X4 -- requirements
Module: demux_1x4

Interface
REQ-001 Parameter WIDTH, default 1, data width of input a and of each output x/y/z/k; legal range 1..64.
REQ-002 Parameter IDLE_VAL, default 0, 1-bit fill value driven on every bit of each deselected output.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 a  input  WIDTH  data to route.
REQ-006 sel  input  2  route select: 00->x, 01->y, 10->z, 11->k.
REQ-007 x  output  WIDTH  channel 0 data, registered.
REQ-008 y  output  WIDTH  channel 1 data, registered.
REQ-009 z  output  WIDTH  channel 2 data, registered.
REQ-010 k  output  WIDTH  channel 3 data, registered.
REQ-011 sel_oh  output  4  registered one-hot of the captured sel; bit0=x, bit3=k.
REQ-012 sel_chg  output  1  registered pulse, high for one cycle when the captured sel differs from the previous captured sel.

Function
REQ-013 Each rising clk edge without rst, the selected output SHALL load a, and every other output SHALL load {WIDTH{IDLE_VAL}}; latency is exactly 1 cycle.
REQ-014 Exactly one sel_oh bit SHALL be high at all times outside reset, matching the channel that carries a.
REQ-015 With WIDTH=1 and IDLE_VAL=0, the registered outputs SHALL equal the combinational truth table x=a&~s1&~s0, y=a&~s1&s0, z=a&s1&~s0, k=a&s1&s0 of the previous cycle's inputs.
REQ-016 A sel change and an a change in the same cycle SHALL both take effect at the next edge; the previous channel drops to idle while the new channel shows the new a.
REQ-017 sel_chg SHALL compare against the internally held previous sel; the first capture after reset SHALL compare against 00.
REQ-018 An unknown/X sel SHALL NOT occur in legal use; the decoder SHALL still map every 2-bit value, with no default-case latch.

Reset
REQ-019 With rst high at a rising edge, x, y, z, k SHALL become {WIDTH{IDLE_VAL}}, sel_oh SHALL become 0000, sel_chg SHALL become 0, and the previous-sel register SHALL become 00.
REQ-020 Reset SHALL take priority over data capture on the same edge; reset asserted mid-stream SHALL discard that cycle's a/sel.
REQ-021 The first edge after rst deasserts SHALL capture a/sel normally.

Structure
REQ-022 Shared package demux_pkg SHALL hold the channel-index constants CH_X=0, CH_Y=1, CH_Z=2, CH_K=3 and the select width constant SEL_W=2.
REQ-023 The sel-to-one-hot decode SHALL be a combinational sub-module named demux_sel_dec (2-bit in, 4-bit one-hot out), instantiated once.
REQ-024 All outputs SHALL come directly from flops, with no combinational path from input to output.

Verification
REQ-025 rst=1 for 2 cycles, then release -> x=y=z=k=0, sel_oh=0000, sel_chg=0 before the first capture.
REQ-026 sel=00, a sequence 1,0,1 on successive cycles -> x follows 1,0,1 one cycle later; y=z=k=0; sel_oh=0001.
REQ-027 Sweep sel 01,10,11, each with a=1,0,1 -> only y/z/k respectively follow a; sel_oh=0010/0100/1000; sel_chg=1 for exactly the first cycle of each new sel.
REQ-028 sel changes 00->11 with a=1 held -> x goes 0 and k goes 1 on the same edge; no cycle with two outputs high.
REQ-029 rst pulsed for one cycle while sel=10, a=1 -> z=0 after that edge, z=1 again one cycle after release, sel_chg=1 (10 versus reset value 00).
REQ-030 WIDTH=8, IDLE_VAL=1, sel=01, a=8'hA5 -> y=8'hA5 and x=z=k=8'hFF.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared constants for the 1-to-4 registered demultiplexer.
// Channel indices line up with the sel encoding and the sel_oh bit order.
package demux_pkg;

    localparam int SEL_W  = 2;
    localparam int NUM_CH = 4;

    localparam int CH_X = 0;
    localparam int CH_Y = 1;
    localparam int CH_Z = 2;
    localparam int CH_K = 3;

endpackage : demux_pkg

// File: rtl/demux_sel_dec.sv
// Combinational decode of the 2-bit route select into a one-hot channel vector.
// Every select value has its own arm, so no code falls through to a held value.
module demux_sel_dec
    import demux_pkg::*;
(
    input  logic [SEL_W-1:0]  sel_i,
    output logic [NUM_CH-1:0] onehot_o
);

    always_comb begin
        onehot_o = '0;
        case (sel_i)
            2'b00:   onehot_o[CH_X] = 1'b1;
            2'b01:   onehot_o[CH_Y] = 1'b1;
            2'b10:   onehot_o[CH_Z] = 1'b1;
            2'b11:   onehot_o[CH_K] = 1'b1;
            default: onehot_o = '0;
        endcase
    end

endmodule : demux_sel_dec

// File: rtl/demux_1x4.sv
// Registered 1-to-4 demultiplexer: the selected channel loads a, the others load
// the idle fill pattern. Also reports the captured select one-hot and a change pulse.
module demux_1x4
    import demux_pkg::*;
#(
    parameter int WIDTH    = 1,
    parameter bit IDLE_VAL = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  a,
    input  logic [SEL_W-1:0]  sel,
    output logic [WIDTH-1:0]  x,
    output logic [WIDTH-1:0]  y,
    output logic [WIDTH-1:0]  z,
    output logic [WIDTH-1:0]  k,
    output logic [NUM_CH-1:0] sel_oh,
    output logic              sel_chg
);

    localparam logic [WIDTH-1:0] FILL = {WIDTH{IDLE_VAL}};

    logic [NUM_CH-1:0] oh_d;
    logic [WIDTH-1:0]  x_d, y_d, z_d, k_d;
    logic              chg_d;

    logic [WIDTH-1:0]  x_q, y_q, z_q, k_q;
    logic [NUM_CH-1:0] oh_q;
    logic              chg_q;
    logic [SEL_W-1:0]  sel_prev_q;

    demux_sel_dec u_sel_dec (
        .sel_i    (sel),
        .onehot_o (oh_d)
    );

    always_comb begin
        x_d   = oh_d[CH_X] ? a : FILL;
        y_d   = oh_d[CH_Y] ? a : FILL;
        z_d   = oh_d[CH_Z] ? a : FILL;
        k_d   = oh_d[CH_K] ? a : FILL;
        chg_d = (sel != sel_prev_q);
    end

    // Reset wins over capture; the previous-sel register returns to 00 so the
    // first capture after reset is judged against channel x.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_q        <= FILL;
            y_q        <= FILL;
            z_q        <= FILL;
            k_q        <= FILL;
            oh_q       <= '0;
            chg_q      <= 1'b0;
            sel_prev_q <= '0;
        end else begin
            x_q        <= x_d;
            y_q        <= y_d;
            z_q        <= z_d;
            k_q        <= k_d;
            oh_q       <= oh_d;
            chg_q      <= chg_d;
            sel_prev_q <= sel;
        end
    end

    assign x       = x_q;
    assign y       = y_q;
    assign z       = z_q;
    assign k       = k_q;
    assign sel_oh  = oh_q;
    assign sel_chg = chg_q;

endmodule : demux_1x4

// File: tb/tb_demux_1x4.sv
// Bench for demux_1x4: a 1-bit/idle-0 instance and an 8-bit/idle-1 instance
// share clock, reset and select, and are checked against a channel-array model.
module tb_demux_1x4;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] sel;
    logic       a1;
    logic [7:0] a8;

    logic       x1, y1, z1, k1;
    logic [3:0] oh1;
    logic       chg1;
    logic [7:0] x8, y8, z8, k8;
    logic [3:0] oh8;
    logic       chg8;

    int n_chk = 0;
    int n_err = 0;

    // Model state: what each channel should hold after the last edge.
    logic [7:0] exp_w1 [4];
    logic [7:0] exp_w8 [4];
    logic [3:0] exp_oh;
    logic       exp_chg;
    logic [1:0] prev_sel;
    bit         in_reset;

    always #5 clk = ~clk;

    demux_1x4 #(.WIDTH(1), .IDLE_VAL(1'b0)) dut1 (
        .clk(clk), .rst(rst), .a(a1), .sel(sel),
        .x(x1), .y(y1), .z(z1), .k(k1), .sel_oh(oh1), .sel_chg(chg1)
    );

    demux_1x4 #(.WIDTH(8), .IDLE_VAL(1'b1)) dut8 (
        .clk(clk), .rst(rst), .a(a8), .sel(sel),
        .x(x8), .y(y8), .z(z8), .k(k8), .sel_oh(oh8), .sel_chg(chg8)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge(input bit r, input logic [1:0] s, input logic a_n, input logic [7:0] a_w);
        if (r) begin
            for (int c = 0; c < 4; c++) begin
                exp_w1[c] = 8'h00;
                exp_w8[c] = 8'hFF;
            end
            exp_oh   = 4'b0000;
            exp_chg  = 1'b0;
            prev_sel = 2'd0;
            in_reset = 1'b1;
        end else begin
            for (int c = 0; c < 4; c++) begin
                exp_w1[c] = (c == int'(s)) ? {7'd0, a_n} : 8'h00;
                exp_w8[c] = (c == int'(s)) ? a_w : 8'hFF;
            end
            exp_oh   = 4'b0001 << s;
            exp_chg  = (s != prev_sel);
            prev_sel = s;
            in_reset = 1'b0;
        end
    endtask

    task automatic check_all();
        chk("x1", x1, exp_w1[0]);
        chk("y1", y1, exp_w1[1]);
        chk("z1", z1, exp_w1[2]);
        k1_chk: chk("k1", k1, exp_w1[3]);
        chk("oh1", oh1, exp_oh);
        chk("chg1", chg1, exp_chg);
        chk("x8", x8, exp_w8[0]);
        chk("y8", y8, exp_w8[1]);
        chk("z8", z8, exp_w8[2]);
        chk("k8", k8, exp_w8[3]);
        chk("oh8", oh8, exp_oh);
        chk("chg8", chg8, exp_chg);
        chk("oh1_ones", $countones(oh1), in_reset ? 0 : 1);
        chk("hi_outs", $countones({x1, y1, z1, k1}),
            $countones({exp_w1[0][0], exp_w1[1][0], exp_w1[2][0], exp_w1[3][0]}));
    endtask

    task automatic step(input bit r, input logic [1:0] s, input logic a_n, input logic [7:0] a_w);
        rst = r;
        sel = s;
        a1  = a_n;
        a8  = a_w;
        @(posedge clk);
        #1;
        model_edge(r, s, a_n, a_w);
        check_all();
    endtask

    initial begin
        rst = 1'b1; sel = 2'b00; a1 = 1'b0; a8 = 8'h00;

        step(1'b1, 2'b00, 1'b1, 8'h3C);
        step(1'b1, 2'b11, 1'b1, 8'hC3);

        step(1'b0, 2'b00, 1'b1, 8'h11);
        step(1'b0, 2'b00, 1'b0, 8'h22);
        step(1'b0, 2'b00, 1'b1, 8'h33);

        for (int s = 1; s < 4; s++) begin
            step(1'b0, 2'(s), 1'b1, 8'h40 + 8'(s));
            step(1'b0, 2'(s), 1'b0, 8'h50 + 8'(s));
            step(1'b0, 2'(s), 1'b1, 8'h60 + 8'(s));
        end

        step(1'b0, 2'b00, 1'b1, 8'h01);
        step(1'b0, 2'b11, 1'b1, 8'h02);

        step(1'b0, 2'b10, 1'b1, 8'h77);
        step(1'b1, 2'b10, 1'b1, 8'h88);
        step(1'b0, 2'b10, 1'b1, 8'h99);

        step(1'b0, 2'b01, 1'b1, 8'hA5);

        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 19) == 0), 2'($urandom_range(0, 3)),
                 1'($urandom), 8'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule : tb_demux_1x4
